// File: rtl/barrett_pkg.sv
// Shared constants and elaboration helpers for the pipelined Barrett reducer.
// The optional statistics counters are enabled by defining BARRETT_STATS_EN.
package barrett_pkg;

    localparam int Q_DEFAULT          = 2273;
    localparam int K_DEFAULT          = 12;
    localparam int TAG_W_DEFAULT      = 4;
    localparam int CORR_STEPS_DEFAULT = 3;

    localparam int DIN_W = 2 * K_DEFAULT;
    localparam int R0_W  = K_DEFAULT + 2;

    typedef enum logic [1:0] {
        CHK_OK      = 2'd0,
        CHK_Q_RANGE = 2'd1,
        CHK_Q_EVEN  = 2'd2,
        CHK_STEPS   = 2'd3
    } barrett_chk_e;

    function automatic longint barrett_mu(input int q, input int k);
        return (longint'(1) << (2 * k)) / longint'(q);
    endfunction

    function automatic int barrett_din_w(input int k);
        return 2 * k;
    endfunction

    function automatic int barrett_r0_w(input int k);
        return k + 2;
    endfunction

    // Q must sit strictly between 2^(K-1) and 2^K so that MU fits in K+1 bits.
    function automatic barrett_chk_e barrett_check(input int q, input int k, input int steps);
        if (!((q > (1 << (k - 1))) && (q < (1 << k))))
            return CHK_Q_RANGE;
        if ((q % 2) == 0)
            return CHK_Q_EVEN;
        if (steps < 1)
            return CHK_STEPS;
        return CHK_OK;
    endfunction

    localparam barrett_chk_e DEFAULT_CHK =
        barrett_check(Q_DEFAULT, K_DEFAULT, CORR_STEPS_DEFAULT);

endpackage

// File: rtl/barrett_cond_sub.sv
// One combinational correction step of the Barrett reducer: r >= Q ? r - Q : r.
module barrett_cond_sub #(
    parameter int W = 14,
    parameter int Q = 2273
) (
    input  logic [W-1:0] i_r,
    output logic [W-1:0] o_r
);

    localparam logic [W-1:0] Q_W = W'(Q);

    logic w_ge;

    assign w_ge = (i_r >= Q_W);
    assign o_r  = w_ge ? (i_r - Q_W) : i_r;

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Three-stage streaming Barrett reducer (din mod Q) with a tag sideband and global stall.
// Define BARRETT_STATS_EN to add the stat_done / stat_corr transfer counters.
module barrett_reduce_pipe
    import barrett_pkg::*;
#(
    parameter int Q          = 2273,
    parameter int K          = 12,
    parameter int TAG_W      = 4,
    parameter int CORR_STEPS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [barrett_din_w(K)-1:0]   in_data,
    input  logic [TAG_W-1:0]              in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [K-1:0]                  out_data,
    output logic [TAG_W-1:0]              out_tag
`ifdef BARRETT_STATS_EN
    ,
    output logic [31:0]                   stat_done,
    output logic [31:0]                   stat_corr
`endif
);

    localparam int W_IN = barrett_din_w(K);
    localparam int W_P  = W_IN + 1;
    localparam int W_R0 = barrett_r0_w(K);

    localparam barrett_chk_e CFG_CHK = barrett_check(Q, K, CORR_STEPS);
    localparam logic [K:0]   MU_V    = (K + 1)'(barrett_mu(Q, K));

    if (CFG_CHK != CHK_OK) begin : g_bad_cfg
        $fatal(1, "barrett_reduce_pipe: illegal configuration Q=%0d K=%0d CORR_STEPS=%0d (code %0d)",
               Q, K, CORR_STEPS, CFG_CHK);
    end

    logic              w_adv;

    logic              r_v1;
    logic [W_IN-1:0]   r_a1;
    logic [W_P-1:0]    r_p1;
    logic [TAG_W-1:0]  r_tag1;

    logic              r_v2;
    logic [W_R0-1:0]   r_r0;
    logic [TAG_W-1:0]  r_tag2;

    logic              r_v3;
    logic [K-1:0]      r_out;
    logic [TAG_W-1:0]  r_tag3;

    logic [W_P-1:0]    w_p;
    logic [K:0]        w_t;
    logic [W_P-1:0]    w_tq;
    logic [W_P-1:0]    w_diff;
    logic [W_R0-1:0]   w_chain [CORR_STEPS+1];
    logic              w_unused_bits;

    // Every stage advances together; a full pipe only moves when the consumer takes a result.
    assign w_adv    = !r_v3 || out_ready;
    assign in_ready = w_adv;

    assign w_p    = W_P'(in_data[W_IN-1:K]) * W_P'(MU_V);
    assign w_t    = r_p1[W_P-1:K];
    assign w_tq   = W_P'(w_t) * W_P'(Q);
    // The true difference is below 4Q, so K+2 low bits carry it exactly.
    assign w_diff = W_P'(r_a1) - w_tq;

    assign w_chain[0] = r_r0;

    for (genvar g = 0; g < CORR_STEPS; g++) begin : g_corr
        barrett_cond_sub #(
            .W (W_R0),
            .Q (Q)
        ) u_cond_sub (
            .i_r (w_chain[g]),
            .o_r (w_chain[g+1])
        );
    end

    assign w_unused_bits = ^{w_diff[W_P-1:W_R0], r_p1[K-1:0], w_chain[CORR_STEPS][W_R0-1:K]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_a1   <= '0;
            r_p1   <= '0;
            r_tag1 <= '0;
        end else if (w_adv) begin
            r_v1   <= in_valid;
            r_a1   <= in_data;
            r_p1   <= w_p;
            r_tag1 <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2   <= 1'b0;
            r_r0   <= '0;
            r_tag2 <= '0;
        end else if (w_adv) begin
            r_v2   <= r_v1;
            r_r0   <= w_diff[W_R0-1:0];
            r_tag2 <= r_tag1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3   <= 1'b0;
            r_out  <= '0;
            r_tag3 <= '0;
        end else if (w_adv) begin
            r_v3   <= r_v2;
            r_out  <= w_chain[CORR_STEPS][K-1:0];
            r_tag3 <= r_tag2;
        end
    end

    assign out_valid = r_v3;
    assign out_data  = r_out;
    assign out_tag   = r_tag3;

`ifdef BARRETT_STATS_EN
    logic        w_corr;
    logic        r_corr3;
    logic [31:0] r_stat_done;
    logic [31:0] r_stat_corr;

    // Two or more subtractions are needed exactly when the raw remainder reaches 2Q.
    assign w_corr = (r_r0 >= W_R0'(2 * Q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_corr3 <= 1'b0;
        end else if (w_adv) begin
            r_corr3 <= w_corr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_done <= '0;
            r_stat_corr <= '0;
        end else if (r_v3 && out_ready) begin
            r_stat_done <= r_stat_done + 32'd1;
            if (r_corr3) begin
                r_stat_corr <= r_stat_corr + 32'd1;
            end
        end
    end

    assign stat_done = r_stat_done;
    assign stat_corr = r_stat_corr;
`endif

endmodule
